pcileech_tlp_dw_packer: RTL

Single-clock, parametrised DWORD-to-beat TLP packer with sync buffering. Accepts a 32-bit DWORD TLP stream with valid/ready backpressure and packs it into DW_PER_BEAT-wide AXI-stream beats for the PCIe core transmit path. Successor to the fixed 2-DWORD pairing logic: beat width and buffer depth are generic, both sides have backpressure, and statistics are exported. Sits between the TLP command demux and the PCIe core s_axis_tx interface, inside the PCIe clock domain.

---
 rtl/pcileech_tlp_pkg.sv | 14 +
 rtl/pcileech_tlp_dw_packer_if.sv | 26 ++
 rtl/pcileech_sync_fifo.sv | 47 ++++
 rtl/pcileech_tlp_dw_packer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pcileech_tlp_pkg.sv
// Shared constants, packer state type and tkeep helper for the TLP DWORD packer.
package pcileech_tlp_pkg;
  localparam int DW_W            = 32;
  localparam int MAX_TLP_DW_DFLT = 1028;

  typedef enum logic {PACK = 1'b0, DROP = 1'b1} pk_state_e;

  // Byte enables for the first nlanes DWORD lanes; callers trim to their beat width.
  function automatic logic [15:0] keep_mask(input int unsigned nlanes);
    keep_mask = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (i < nlanes) keep_mask[i*4 +: 4] = 4'hF;
  endfunction
endpackage

// File: rtl/pcileech_tlp_dw_packer_if.sv
// DWORD input stream and packed AXI-stream output of the TLP packer.
// slave = packer side, master = upstream source / downstream sink side.
interface pcileech_tlp_dw_packer_if
  import pcileech_tlp_pkg::*;
#(
  parameter int DW_PER_BEAT = 2
);
  logic [DW_W-1:0]               in_data;
  logic                          in_last;
  logic                          in_valid;
  logic                          in_ready;
  logic [DW_W*DW_PER_BEAT-1:0]   out_tdata;
  logic [4*DW_PER_BEAT-1:0]      out_tkeep;
  logic                          out_tlast;
  logic                          out_tvalid;
  logic                          out_tready;

  modport slave (
    input  in_data, in_last, in_valid, out_tready,
    output in_ready, out_tdata, out_tkeep, out_tlast, out_tvalid
  );
  modport master (
    output in_data, in_last, in_valid, out_tready,
    input  in_ready, out_tdata, out_tkeep, out_tlast, out_tvalid
  );
endinterface

// File: rtl/pcileech_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Writer must not push while level==DEPTH; read data is zero while empty.
module pcileech_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rptr];

  // pointers wrap naturally at DEPTH (power of two); level tracks push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({wr_en, do_rd})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // storage array, no reset needed: reads are masked while empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/pcileech_tlp_dw_packer.sv
// Packs a 32-bit DWORD TLP stream into DW_PER_BEAT-wide AXI-stream beats.
// Optional length guard: define PCILEECH_TLP_LEN_CHECK_EN to truncate TLPs
// longer than MAX_TLP_DW and drop the remainder of the oversized TLP.
module pcileech_tlp_dw_packer
  import pcileech_tlp_pkg::*;
#(
  parameter int DW_PER_BEAT = 2,
  parameter int DEPTH       = 16,
  parameter int MAX_TLP_DW  = MAX_TLP_DW_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  pcileech_tlp_dw_packer_if.slave bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             stat_tlp_count,
  output logic [15:0]             stat_trunc_count
);
  localparam int LW  = $clog2(DW_PER_BEAT);
  localparam int DBW = DW_W * DW_PER_BEAT;
  localparam int KBW = 4 * DW_PER_BEAT;
  localparam int FW  = DBW + KBW + 1;
  localparam int LVW = $clog2(DEPTH) + 1;

  if (!(DW_PER_BEAT == 2 || DW_PER_BEAT == 4) || DEPTH < 4 ||
      (DEPTH & (DEPTH - 1)) != 0 || MAX_TLP_DW < 1) begin : g_bad_cfg
    $error("pcileech_tlp_dw_packer: illegal parameter set");
  end

  logic                             rdy_en, full, accept, pop;
  logic                             drop, trunc, eff_last, complete, push_now;
  logic                             push_q, fifo_empty;
  logic [LW-1:0]                    lane;
  logic [DW_PER_BEAT-1:0][DW_W-1:0] hold, beat_data;
  logic [KBW-1:0]                   beat_keep;
  logic [FW-1:0]                    beat_q, fifo_out;
  logic [LVW-1:0]                   fifo_level;

  // level counts the beat in the staging register, so full already covers it
  assign full         = (level == LVW'(DEPTH));
  assign bus.in_ready = rdy_en & (~full | drop);
  assign accept       = bus.in_valid & bus.in_ready;
  assign eff_last     = bus.in_last | trunc;
  assign complete     = (lane == LW'(DW_PER_BEAT - 1)) | eff_last;
  assign push_now     = accept & ~drop & complete;

  // current DWORD lands in lane `lane`, earlier lanes come from hold, later ones stay zero
  for (genvar g = 0; g < DW_PER_BEAT; g++) begin : g_lane
    assign beat_data[g] = (LW'(g) == lane) ? bus.in_data :
                          (LW'(g) <  lane) ? hold[g] : '0;
  end
  assign beat_keep = KBW'(keep_mask(32'(lane) + 32'd1));

  // in_ready held low through reset and raised one cycle after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  // lane pointer and partial-beat holding lanes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= '0;
      hold <= '0;
    end else if (accept && !drop) begin
      hold[lane] <= bus.in_data;
      lane       <= complete ? '0 : lane + LW'(1);
    end
  end

  // one-cycle staging of completed beats ahead of the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q <= 1'b0;
      beat_q <= '0;
    end else begin
      push_q <= push_now;
      if (push_now) beat_q <= {eff_last, beat_keep, beat_data};
    end
  end

  pcileech_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (beat_q),
    .rd_en   (pop),
    .rd_data (fifo_out),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bus.out_tvalid = ~fifo_empty;
  assign pop            = bus.out_tvalid & bus.out_tready;
  assign {bus.out_tlast, bus.out_tkeep, bus.out_tdata} = fifo_out;
  assign level          = fifo_level + LVW'(push_q);

  // count TLPs as their final beat leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     stat_tlp_count <= '0;
    else if (pop && bus.out_tlast) stat_tlp_count <= stat_tlp_count + 16'd1;
  end

`ifdef PCILEECH_TLP_LEN_CHECK_EN
  localparam int CW = $clog2(MAX_TLP_DW + 1);

  pk_state_e     state_q, state_d;
  logic [CW-1:0] dw_cnt;

  assign drop  = (state_q == DROP);
  // dw_cnt holds DWORDs already taken, so this DWORD is number MAX_TLP_DW
  assign trunc = ~drop & (dw_cnt == CW'(MAX_TLP_DW - 1)) & ~bus.in_last;

  // packer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PACK;
    else      state_q <= state_d;
  end

  // enter DROP on truncation, leave after the real last DWORD is swallowed
  always_comb begin
    state_d = state_q;
    case (state_q)
      PACK:    if (accept && trunc)       state_d = DROP;
      DROP:    if (accept && bus.in_last) state_d = PACK;
      default: state_d = PACK;
    endcase
  end

  // per-TLP DWORD counter and truncation statistic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dw_cnt           <= '0;
      stat_trunc_count <= '0;
    end else begin
      if (accept && !drop) dw_cnt <= eff_last ? '0 : dw_cnt + CW'(1);
      if (accept && trunc) stat_trunc_count <= stat_trunc_count + 16'd1;
    end
  end
`else
  assign drop             = 1'b0;
  assign trunc            = 1'b0;
  assign stat_trunc_count = '0;
`endif
endmodule
